// File: rtl/la_bec_if.sv
// la_bec_if: LA command/readback lines plus the BEC core launch/result
// signals, bundled so the bridge sees them as one port.
//   la_data_in  : firmware command word (wdata, addr, wr/start/rd toggles)
//   la_oenb     : LA output enables, low bits gate the command inputs
//   la_data_out : readback word (rdata, acks, state, error flags)
//   core_op     : flat operand buffer, word 0 at LSBs
//   core_start  : one-cycle launch pulse to the core
//   core_done   : one-cycle completion pulse from the core
//   core_result : core result words, sampled on core_done
// master = firmware/core side, slave = bridge side.
interface la_bec_if #(
   parameter int NWORDS = 6,
   parameter int RWORDS = 6
);
   logic [127:0]          la_data_in;
   logic [127:0]          la_oenb;
   logic [127:0]          la_data_out;
   logic [NWORDS*32-1:0]  core_op;
   logic                  core_start;
   logic                  core_done;
   logic [RWORDS*32-1:0]  core_result;

   modport master (
      output la_data_in, la_oenb, core_done, core_result,
      input  la_data_out, core_op, core_start
   );

   modport slave (
      input  la_data_in, la_oenb, core_done, core_result,
      output la_data_out, core_op, core_start
   );
endinterface

// File: rtl/la_bec_bridge.sv
// la_bec_bridge: user-side responder of the LA BEC transfer protocol.
// Firmware writes operand words, launches the BEC core and reads back
// operands/results, all paced by toggle bits on la_data_in.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : la_bec_if slave modport (LA lines and BEC core signals)
//
// state | meaning
// IDLE  | no run since reset, operands may be written
// RUN   | core launched, waiting for core_done or timeout
// DONE  | run finished (result captured or timed out), relaunch allowed
module la_bec_bridge #(
   parameter int NWORDS  = 6,
   parameter int RWORDS  = 6,
   parameter int TIMEOUT = 65535
) (
   input  logic     clk,
   input  logic     rst_n,
   la_bec_if.slave  bus
);

   localparam logic [16:0] TMR_LOAD = 17'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   state_t        state, state_nxt;

   logic [39:0]   la_q;
   logic [2:0]    tgl_d;
   logic          cmd_en;
   logic          wr_evt, start_evt, rd_evt;
   logic [31:0]   wdata;
   logic [4:0]    addr;
   logic          in_run, launch, tmr_tc, run_done, run_timeout;
   logic          wr_in_range, rd_hit;
   logic [31:0]   rd_word;
   logic [16:0]   tmr;
   logic [31:0]   op_buf  [NWORDS];
   logic [31:0]   res_buf [RWORDS];
   logic [31:0]   rdata;
   logic          rd_ack, wr_ack, core_start_q;
   logic          err_addr, err_busy, err_timeout;
   logic          unused_la;

   assign cmd_en    = (bus.la_oenb[39:0] == 40'd0);
   assign unused_la = ^{bus.la_data_in[127:40], bus.la_oenb[127:40]};

   // While any command enable is high the register freezes, so neither data
   // nor toggles move and no spurious events can be seen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         la_q  <= '0;
         tgl_d <= '0;
      end else begin
         if (cmd_en) la_q <= bus.la_data_in[39:0];
         tgl_d <= la_q[39:37];
      end
   end

   assign wdata     = la_q[31:0];
   assign addr      = la_q[36:32];
   assign wr_evt    = la_q[37] ^ tgl_d[0];
   assign start_evt = la_q[38] ^ tgl_d[1];
   assign rd_evt    = la_q[39] ^ tgl_d[2];

   assign in_run      = (state == ST_RUN);
   assign launch      = start_evt && !in_run;
   // Timer is loaded with TIMEOUT at launch and expires on the edge where it
   // would step from 1 to 0, i.e. after exactly TIMEOUT cycles in RUN.
   assign tmr_tc      = (tmr <= 17'd1);
   assign run_done    = in_run && bus.core_done;
   assign run_timeout = in_run && !bus.core_done && tmr_tc;
   assign wr_in_range = ({27'd0, addr} < 32'(NWORDS));

   always_comb begin
      rd_word = '0;
      rd_hit  = 1'b0;
      if (!addr[4]) begin
         for (int i = 0; i < NWORDS; i++) begin
            if (addr[3:0] == i[3:0]) begin
               rd_word = op_buf[i];
               rd_hit  = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < RWORDS; i++) begin
            if (addr[3:0] == i[3:0]) begin
               rd_word = res_buf[i];
               rd_hit  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE: if (start_evt) state_nxt = ST_RUN;
         ST_RUN:           if (bus.core_done || tmr_tc) state_nxt = ST_DONE;
         default:          state_nxt = ST_IDLE;
      endcase
   end

   // Error clears on launch come first so a same-edge error still sticks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NWORDS; i++) op_buf[i] <= '0;
         for (int i = 0; i < RWORDS; i++) res_buf[i] <= '0;
         tmr          <= '0;
         rdata        <= '0;
         rd_ack       <= 1'b0;
         wr_ack       <= 1'b0;
         core_start_q <= 1'b0;
         err_addr     <= 1'b0;
         err_busy     <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         core_start_q <= launch;

         if (launch) begin
            err_addr    <= 1'b0;
            err_busy    <= 1'b0;
            err_timeout <= 1'b0;
            tmr         <= TMR_LOAD;
         end else if (in_run && !tmr_tc) begin
            tmr <= tmr - 17'd1;
         end

         if (wr_evt) begin
            wr_ack <= ~wr_ack;
            if (in_run) begin
               err_busy <= 1'b1;
            end else if (!wr_in_range) begin
               err_addr <= 1'b1;
            end else begin
               for (int i = 0; i < NWORDS; i++) begin
                  if (addr[3:0] == i[3:0]) op_buf[i] <= wdata;
               end
            end
         end

         if (start_evt && in_run) err_busy <= 1'b1;

         if (rd_evt) begin
            rd_ack <= ~rd_ack;
            rdata  <= rd_word;
            if (!rd_hit) err_addr <= 1'b1;
         end

         if (run_timeout) err_timeout <= 1'b1;

         if (run_done) begin
            for (int i = 0; i < RWORDS; i++) res_buf[i] <= bus.core_result[i*32 +: 32];
         end
      end
   end

   for (genvar g = 0; g < NWORDS; g++) begin : g_op
      assign bus.core_op[g*32 +: 32] = op_buf[g];
   end

   assign bus.core_start  = core_start_q;
   assign bus.la_data_out = {89'd0, err_timeout, err_busy, err_addr, state,
                             wr_ack, rd_ack, rdata};

endmodule
